// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use/RAW stalls, control flushes, operand forwarding, multi-cycle memory wait.
// Optional feature macro HAZARD_FORWARDING_EN enables E-stage forwarding (otherwise RAW hazards stall).
module hazard_ctrl #(
  parameter int MEM_LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MemAccessM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemBusy
);

  typedef enum logic [0:0] {IDLE, MEM_WAIT} state_t;

  localparam logic [3:0] CNT_INIT = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mem_stall;
  logic       data_stall;
  logic [1:0] fwd_a, fwd_b;

  // Destination register rd (non-x0) matches either source
  function automatic logic dep(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return (rd != 5'd0) && ((rd == a) || (rd == b));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // MemAccessM is only looked at in IDLE; the held access is ignored while waiting
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (MemAccessM && (MEM_LATENCY > 1)) begin
          mem_stall = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (cnt != 4'd0) begin
          mem_stall = 1'b1;
          cnt_nxt   = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst)
      mem_stall = 1'b0;
  end

`ifdef HAZARD_FORWARDING_EN
  always_comb begin
    data_stall = ResultSrcE && RegWriteE && dep(RdE, Rs1D, Rs2D);
    fwd_a      = fwd_sel(Rs1E);
    fwd_b      = fwd_sel(Rs2E);
  end
`else
  // Without forwarding any in-flight producer in E or M must drain first
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE, fwd_sel(5'd0)};

  always_comb begin
    data_stall = (RegWriteE && dep(RdE, Rs1D, Rs2D)) ||
                 (RegWriteM && dep(RdM, Rs1D, Rs2D));
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
  end
`endif

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    MemBusy   = mem_stall;
    if (rst) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else if (mem_stall) begin
      // Frozen E keeps PCSrcE, so the control flush lands in the first free cycle
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = data_stall;
      StallD = data_stall;
      FlushE = data_stall || PCSrcE;
      FlushD = PCSrcE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations adapt to HAZARD_FORWARDING_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy;
  logic [1:0] ForwardAE, ForwardBE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_LATENCY(3)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemBusy(MemBusy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    ResultSrcE = 0; PCSrcE = 0; MemAccessM = 0;
  endtask

  // Advance to just after the next rising edge, where new inputs are applied
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    cyc();
    // Reset outputs, with activity on inputs that must be masked
    MemAccessM = 1; RegWriteM = 1; RdM = 7; Rs1E = 7; Rs2E = 7; PCSrcE = 1;
    sample();
    check("rst_stallf", StallF, 0);
    check("rst_stallm", StallM, 0);
    check("rst_flushd", FlushD, 1);
    check("rst_flushe", FlushE, 1);
    check("rst_flushw", FlushW, 1);
    check("rst_fwda", ForwardAE, 0);
    check("rst_fwdb", ForwardBE, 0);
    check("rst_busy", MemBusy, 0);

    cyc(); rst = 1'b0; clr();
    sample();
    check("idle_busy", MemBusy, 0);
    check("idle_flushw", FlushW, 0);

    // Memory wait, latency 3: cycles 0,1 stalled, 2 free; load hazard suppressed
    cyc(); MemAccessM = 1; ResultSrcE = 1; RegWriteE = 1; RdE = 4; Rs1D = 4;
    sample();
    check("m0_busy", MemBusy, 1);
    check("m0_stallf", StallF, 1);
    check("m0_stalle", StallE, 1);
    check("m0_stallm", StallM, 1);
    check("m0_flushw", FlushW, 1);
    check("m0_flushe", FlushE, 0);
    cyc(); clr(); MemAccessM = 1; PCSrcE = 1;
    sample();
    check("m1_busy", MemBusy, 1);
    check("m1_flushd", FlushD, 0);
    check("m1_flushe", FlushE, 0);
    cyc();
    sample();
    check("m2_busy", MemBusy, 0);
    check("m2_flushd", FlushD, 1);
    check("m2_flushe", FlushE, 1);
    check("m2_stallm", StallM, 0);
    check("m2_flushw", FlushW, 0);
    // Back-to-back access starts a new wait immediately
    cyc(); PCSrcE = 0;
    sample();
    check("m3_busy", MemBusy, 1);
    cyc(); MemAccessM = 0;
    sample();
    check("m4_busy", MemBusy, 1);
    cyc();
    sample();
    check("m5_busy", MemBusy, 0);
    cyc();
    sample();
    check("m6_busy", MemBusy, 0);

    // Load-use on Rs2D and on Rs1D
    cyc(); clr(); ResultSrcE = 1; RegWriteE = 1; RdE = 5; Rs2D = 5;
    sample();
    check("lu_stallf", StallF, 1);
    check("lu_stalld", StallD, 1);
    check("lu_flushe", FlushE, 1);
    check("lu_flushd", FlushD, 0);
    check("lu_stalle", StallE, 0);
    cyc(); Rs2D = 0; Rs1D = 5;
    sample();
    check("lu1_stalld", StallD, 1);
    // Non-load producer in E: only a stall when forwarding is absent
    cyc(); ResultSrcE = 0;
    sample();
    check("alu_e_stalld", StallD, FWD ? 0 : 1);

    // x0 never hazards or forwards
    cyc(); clr(); ResultSrcE = 1; RegWriteE = 1; RdE = 0; Rs1D = 0;
    RegWriteM = 1; RdM = 0; Rs1E = 0;
    sample();
    check("x0_stalld", StallD, 0);
    check("x0_fwda", ForwardAE, 0);

    // Forward priority M over W
    cyc(); clr(); RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 7;
    sample();
    check("fwd_m_a", ForwardAE, FWD ? 2 : 0);
    check("fwd_m_b", ForwardBE, FWD ? 2 : 0);
    cyc(); RegWriteM = 0;
    sample();
    check("fwd_w_a", ForwardAE, FWD ? 1 : 0);
    cyc(); RdW = 9;
    sample();
    check("fwd_none_a", ForwardAE, 0);

    // Reset mid-wait abandons it; next cycle is IDLE and accepts a new access
    cyc(); clr(); MemAccessM = 1;
    sample();
    check("rw_busy0", MemBusy, 1);
    cyc(); rst = 1'b1;
    sample();
    check("rw_rst_busy", MemBusy, 0);
    check("rw_rst_flushd", FlushD, 1);
    cyc(); rst = 1'b0;
    sample();
    check("rw_idle_busy", MemBusy, 1);
    cyc(); MemAccessM = 0;
    cyc();
    sample();
    check("rw_done_busy", MemBusy, 0);

    // RAW against M producer
    cyc(); clr(); RegWriteM = 1; RdM = 3; Rs1D = 3;
    sample();
    check("raw_m_stalld", StallD, FWD ? 0 : 1);
    check("raw_m_flushe", FlushE, FWD ? 0 : 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
